// File: rtl/alu_op_sequencer.sv
// Handshaked ALU opcode sequencer: accepts one opcode per transaction and drives a
// registered one-hot ALU select, expanding shifts into single-bit steps.
module alu_op_sequencer #(
  parameter int OPC_W   = 4,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [11:0]        sel,
  output logic               sel_valid,
  output logic [SHAMT_W-1:0] step,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               illegal_seen
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, FAULT} state_t;

  localparam logic [SHAMT_W-1:0] ONE = 1;

  state_t             state_q;
  logic [11:0]        sel_q;
  logic               sel_valid_q;
  logic [SHAMT_W-1:0] step_q;
  logic [SHAMT_W-1:0] last_q;
  logic               done_q;
  logic               illegal_q;
  logic               illegal_seen_q;

  logic [11:0]        op_sel_d;
  logic               op_illegal_d;
  logic               is_shift_d;
  logic               hi_nz_d;
  logic [SHAMT_W-1:0] step_d;

  function automatic logic [11:0] decode_sel(input logic [3:0] op);
    case (op)
      4'h0:    return 12'h001;
      4'h1:    return 12'h002;
      4'h2:    return 12'h004;
      4'h3:    return 12'h008;
      4'h4:    return 12'h010;
      4'h5:    return 12'h020;
      4'h6:    return 12'h040;
      4'h8:    return 12'h080;
      4'h9:    return 12'h100;
      4'hA:    return 12'h200;
      4'hB:    return 12'h400;
      4'hF:    return 12'h800;
      default: return 12'h000;
    endcase
  endfunction

  generate
    if (OPC_W > 4) begin : g_hi
      assign hi_nz_d = |opcode[OPC_W-1:4];
    end else begin : g_nohi
      assign hi_nz_d = 1'b0;
    end
  endgenerate

  // Unmapped low codes decode to zero, so a zero select doubles as the illegal marker.
  always_comb begin
    op_sel_d     = decode_sel(opcode[3:0]);
    op_illegal_d = hi_nz_d || (op_sel_d == 12'h000);
    is_shift_d   = !op_illegal_d && ((opcode[3:0] == 4'hA) || (opcode[3:0] == 4'hB));
    step_d       = step_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sel_q          <= 12'h000;
      sel_valid_q    <= 1'b0;
      step_q         <= '0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
      illegal_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            step_q <= '0;
            if (op_illegal_d) begin
              state_q        <= FAULT;
              sel_q          <= 12'h000;
              sel_valid_q    <= 1'b0;
              done_q         <= 1'b1;
              illegal_q      <= 1'b1;
              illegal_seen_q <= 1'b1;
            end else if (is_shift_d && (shamt != '0)) begin
              state_q     <= SHIFT;
              sel_q       <= op_sel_d;
              sel_valid_q <= 1'b1;
              done_q      <= (shamt == ONE);
              last_q      <= shamt - ONE;
            end else if (is_shift_d) begin
              // Zero-length shift completes as a no-op without touching the ALU.
              state_q     <= EXEC;
              sel_q       <= 12'h000;
              sel_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q     <= EXEC;
              sel_q       <= op_sel_d;
              sel_valid_q <= 1'b1;
              done_q      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (step_q == last_q) begin
            state_q     <= IDLE;
            sel_q       <= 12'h000;
            sel_valid_q <= 1'b0;
            step_q      <= '0;
            done_q      <= 1'b0;
          end else begin
            step_q <= step_d;
            done_q <= (step_d == last_q);
          end
        end
        default: begin
          state_q     <= IDLE;
          sel_q       <= 12'h000;
          sel_valid_q <= 1'b0;
          step_q      <= '0;
          done_q      <= 1'b0;
          illegal_q   <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready     = (state_q == IDLE) && !rst;
  assign busy         = (state_q != IDLE);
  assign sel          = sel_q;
  assign sel_valid    = sel_valid_q;
  assign step         = step_q;
  assign done         = done_q;
  assign illegal      = illegal_q;
  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  opcode;
  logic [3:0]  shamt;
  logic [11:0] sel;
  logic        sel_valid;
  logic [3:0]  step;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        illegal_seen;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.OPC_W(4), .SHAMT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .opcode       (opcode),
    .shamt        (shamt),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .step         (step),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_shift(input logic [3:0] op, input int k, input logic [11:0] exp_sel);
    opcode   = op;
    shamt    = k[3:0];
    op_valid = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      chk("shift_sel", {20'h0, sel}, {20'h0, exp_sel});
      chk("shift_vld", {31'h0, sel_valid}, 32'd1);
      chk("shift_step", {28'h0, step}, i);
      chk("shift_done", {31'h0, done}, (i == k - 1) ? 32'd1 : 32'd0);
      chk("shift_busy", {31'h0, busy}, 32'd1);
      chk("shift_rdy", {31'h0, op_ready}, 32'd0);
    end
    @(negedge clk);
    chk("shift_end_sel", {20'h0, sel}, 32'h0);
    chk("shift_end_rdy", {31'h0, op_ready}, 32'd1);
    chk("shift_end_done", {31'h0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; opcode = 4'h0; shamt = 4'h0;
    @(negedge clk);
    chk("rst_ready", {31'h0, op_ready}, 32'd0);
    @(negedge clk);
    chk("rst_sel", {20'h0, sel}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_seen", {31'h0, illegal_seen}, 32'd0);
    rst = 1'b0;
    #1 chk("idle_ready", {31'h0, op_ready}, 32'd1);

    // XOR single transaction
    opcode = 4'h3; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; opcode = 4'h5;
    chk("xor_sel", {20'h0, sel}, 32'h008);
    chk("xor_vld", {31'h0, sel_valid}, 32'd1);
    chk("xor_done", {31'h0, done}, 32'd1);
    chk("xor_busy", {31'h0, busy}, 32'd1);
    chk("xor_rdy", {31'h0, op_ready}, 32'd0);
    @(negedge clk);
    chk("xor_end_rdy", {31'h0, op_ready}, 32'd1);
    chk("xor_end_sel", {20'h0, sel}, 32'h0);
    chk("xor_end_done", {31'h0, done}, 32'd0);

    // CLEAR then SUB with op_valid held: accepted two cycles apart
    opcode = 4'hF; op_valid = 1'b1;
    @(negedge clk);
    chk("clr_sel", {20'h0, sel}, 32'h800);
    chk("clr_done", {31'h0, done}, 32'd1);
    opcode = 4'h9;
    @(negedge clk);
    chk("gap_sel", {20'h0, sel}, 32'h0);
    chk("gap_vld", {31'h0, sel_valid}, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    chk("sub_sel", {20'h0, sel}, 32'h100);
    chk("sub_done", {31'h0, done}, 32'd1);
    @(negedge clk);
    chk("sub_end_sel", {20'h0, sel}, 32'h0);

    run_shift(4'hB, 5, 12'h400);
    run_shift(4'hB, 15, 12'h400);
    run_shift(4'hA, 1, 12'h200);

    // SHR by zero is a one-cycle no-op
    opcode = 4'hA; shamt = 4'h0; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("nop_done", {31'h0, done}, 32'd1);
    chk("nop_vld", {31'h0, sel_valid}, 32'd0);
    chk("nop_sel", {20'h0, sel}, 32'h0);
    chk("nop_busy", {31'h0, busy}, 32'd1);
    @(negedge clk);
    chk("nop_end_rdy", {31'h0, op_ready}, 32'd1);

    // Illegal opcode, then sticky flag across a legal op
    opcode = 4'hD; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("ill_pulse", {31'h0, illegal}, 32'd1);
    chk("ill_done", {31'h0, done}, 32'd1);
    chk("ill_vld", {31'h0, sel_valid}, 32'd0);
    chk("ill_seen", {31'h0, illegal_seen}, 32'd1);
    @(negedge clk);
    chk("ill_pulse_end", {31'h0, illegal}, 32'd0);
    chk("ill_seen_hold", {31'h0, illegal_seen}, 32'd1);
    opcode = 4'h0; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("and_sel", {20'h0, sel}, 32'h001);
    chk("and_seen", {31'h0, illegal_seen}, 32'd1);
    chk("and_ill", {31'h0, illegal}, 32'd0);
    @(negedge clk);
    opcode = 4'h7; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("ill7_pulse", {31'h0, illegal}, 32'd1);
    chk("ill7_sel", {20'h0, sel}, 32'h0);
    @(negedge clk);

    // Reset during step 3 of an 8-step SHR
    opcode = 4'hA; shamt = 4'h8; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_step", {28'h0, step}, 32'd3);
    rst = 1'b1;
    #1 chk("abort_rdy_rst", {31'h0, op_ready}, 32'd0);
    @(negedge clk);
    chk("abort_sel", {20'h0, sel}, 32'h0);
    chk("abort_vld", {31'h0, sel_valid}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_step0", {28'h0, step}, 32'd0);
    chk("abort_seen", {31'h0, illegal_seen}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_rdy", {31'h0, op_ready}, 32'd1);
    opcode = 4'h8; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("add_sel", {20'h0, sel}, 32'h080);
    chk("add_done", {31'h0, done}, 32'd1);
    @(negedge clk);
    chk("add_end_busy", {31'h0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
